// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one asynchronous SRAM between a read-only video
// fetch port and a read/write CPU port. Each requester posts a one-cycle
// strobe, is parked in a pending slot if the SRAM is busy, and is answered
// with a one-cycle ack. The FSM sequences address setup, the WE_n pulse and
// the data hold so the SRAM never sees address or data move while WE_n is low.
module sram_arbiter #(
   parameter int ACCESS_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        vid_req,
   input  logic [18:0] vid_addr,
   output logic [7:0]  vid_data,
   output logic        vid_ack,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [18:0] cpu_addr,
   input  logic [7:0]  cpu_din,
   output logic [7:0]  cpu_dout,
   output logic        cpu_ack,
   output logic [18:0] sram_addr,
   inout  wire  [7:0]  sram_data,
   output logic        sram_we_n
);

   localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ACCESS_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD,
      ST_WR_SETUP,
      ST_WR_PULSE,
      ST_WR_HOLD
   } state_t;

   state_t           state_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic             owner_cpu_reg;
   logic             last_vid_reg;

   logic             vid_pend_reg;
   logic [18:0]      vid_addr_reg;
   logic             cpu_pend_reg;
   logic             cpu_we_reg;
   logic [18:0]      cpu_addr_reg;
   logic [7:0]       cpu_din_reg;

   logic [18:0]      sram_addr_reg;
   logic             sram_we_n_reg;
   logic             oe_reg;
   logic [7:0]       wdata_reg;
   logic [7:0]       vid_data_reg;
   logic [7:0]       cpu_dout_reg;
   logic             vid_ack_reg;
   logic             cpu_ack_reg;

   logic             busy;
   logic             vid_take;
   logic             cpu_take;
   logic             vid_cand;
   logic             cpu_cand;
   logic             grant_vid;
   logic             grant_cpu;
   logic [18:0]      vid_sel_addr;
   logic [18:0]      cpu_sel_addr;
   logic             cpu_sel_we;
   logic [7:0]       cpu_sel_din;
   logic [18:0]      grant_addr;

   // Strobe acceptance and arbitration; a pending slot takes priority over a new strobe
   always_comb begin
      busy         = (state_reg != ST_IDLE);
      // a strobe is dropped while its own slot is full or its own access is running
      vid_take     = vid_req & ~vid_pend_reg & ~(busy & ~owner_cpu_reg);
      cpu_take     = cpu_req & ~cpu_pend_reg & ~(busy & owner_cpu_reg);
      vid_cand     = ~busy & (vid_pend_reg | vid_req);
      cpu_cand     = ~busy & (cpu_pend_reg | cpu_req);
      // video wins a tie unless it had the previous grant
      grant_vid    = vid_cand & (~cpu_cand | ~last_vid_reg);
      grant_cpu    = cpu_cand & ~grant_vid;
      vid_sel_addr = vid_pend_reg ? vid_addr_reg : vid_addr;
      cpu_sel_addr = cpu_pend_reg ? cpu_addr_reg : cpu_addr;
      cpu_sel_we   = cpu_pend_reg ? cpu_we_reg   : cpu_we;
      cpu_sel_din  = cpu_pend_reg ? cpu_din_reg  : cpu_din;
      grant_addr   = grant_cpu ? cpu_sel_addr : vid_sel_addr;
   end

   // Request slots, SRAM sequencing FSM and all registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= ST_IDLE;
         cnt_reg       <= '0;
         owner_cpu_reg <= 1'b0;
         last_vid_reg  <= 1'b0;
         vid_pend_reg  <= 1'b0;
         vid_addr_reg  <= '0;
         cpu_pend_reg  <= 1'b0;
         cpu_we_reg    <= 1'b0;
         cpu_addr_reg  <= '0;
         cpu_din_reg   <= '0;
         sram_addr_reg <= '0;
         sram_we_n_reg <= 1'b1;
         oe_reg        <= 1'b0;
         wdata_reg     <= '0;
         vid_data_reg  <= '0;
         cpu_dout_reg  <= '0;
         vid_ack_reg   <= 1'b0;
         cpu_ack_reg   <= 1'b0;
      end else begin
         vid_ack_reg <= 1'b0;
         cpu_ack_reg <= 1'b0;

         if (vid_take) begin
            vid_addr_reg <= vid_addr;
         end
         if (cpu_take) begin
            cpu_we_reg   <= cpu_we;
            cpu_addr_reg <= cpu_addr;
            cpu_din_reg  <= cpu_din;
         end
         if (busy) begin
            vid_pend_reg <= vid_pend_reg | vid_take;
            cpu_pend_reg <= cpu_pend_reg | cpu_take;
         end else begin
            vid_pend_reg <= vid_cand & ~grant_vid;
            cpu_pend_reg <= cpu_cand & ~grant_cpu;
         end

         case (state_reg)
            ST_IDLE: begin
               if (grant_vid | grant_cpu) begin
                  sram_addr_reg <= grant_addr;
                  owner_cpu_reg <= grant_cpu;
                  last_vid_reg  <= grant_vid;
                  if (grant_cpu & cpu_sel_we) begin
                     wdata_reg     <= cpu_sel_din;
                     oe_reg        <= 1'b1;
                     sram_we_n_reg <= 1'b1;
                     state_reg     <= ST_WR_SETUP;
                  end else begin
                     cnt_reg   <= CNT_INIT;
                     state_reg <= ST_RD;
                  end
               end
            end
            ST_RD: begin
               if (cnt_reg == '0) begin
                  if (owner_cpu_reg) begin
                     cpu_dout_reg <= sram_data;
                     cpu_ack_reg  <= 1'b1;
                  end else begin
                     vid_data_reg <= sram_data;
                     vid_ack_reg  <= 1'b1;
                  end
                  state_reg <= ST_IDLE;
               end else begin
                  cnt_reg <= cnt_reg - 1'b1;
               end
            end
            ST_WR_SETUP: begin
               sram_we_n_reg <= 1'b0;
               cnt_reg       <= CNT_INIT;
               state_reg     <= ST_WR_PULSE;
            end
            ST_WR_PULSE: begin
               if (cnt_reg == '0) begin
                  sram_we_n_reg <= 1'b1;
                  state_reg     <= ST_WR_HOLD;
               end else begin
                  cnt_reg <= cnt_reg - 1'b1;
               end
            end
            ST_WR_HOLD: begin
               oe_reg      <= 1'b0;
               cpu_ack_reg <= 1'b1;
               state_reg   <= ST_IDLE;
            end
            default: begin
               sram_we_n_reg <= 1'b1;
               oe_reg        <= 1'b0;
               state_reg     <= ST_IDLE;
            end
         endcase
      end
   end

   // Data bus is driven per bit only while a write sequence owns it
   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_bus
         assign sram_data[gi] = oe_reg ? wdata_reg[gi] : 1'bz;
      end
   endgenerate

   assign sram_addr = sram_addr_reg;
   assign sram_we_n = sram_we_n_reg;
   assign vid_data  = vid_data_reg;
   assign vid_ack   = vid_ack_reg;
   assign cpu_dout  = cpu_dout_reg;
   assign cpu_ack   = cpu_ack_reg;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: two instances (ACCESS_CYCLES=2 and =1) share the
// same stimulus, each with its own SRAM model. A transaction-level reference
// model (grant time + fixed access duration) predicts acks, data, address,
// WE_n and bus ownership for every cycle.
module tb_sram_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        vid_req;
   logic [18:0] vid_addr;
   logic        cpu_req;
   logic        cpu_we;
   logic [18:0] cpu_addr;
   logic [7:0]  cpu_din;

   logic [7:0]  vid_data_a, vid_data_b, cpu_dout_a, cpu_dout_b;
   logic        vid_ack_a, vid_ack_b, cpu_ack_a, cpu_ack_b;
   logic [18:0] sram_addr_a, sram_addr_b;
   logic        sram_we_n_a, sram_we_n_b;
   wire  [7:0]  bus_a;
   wire  [7:0]  bus_b;

   logic [7:0]  sram_mem_a [0:524287];
   logic [7:0]  sram_mem_b [0:524287];
   logic [7:0]  ref_mem    [2][0:524287];
   logic [7:0]  sram_q_a, sram_q_b;
   logic        tb_drv [2];

   always #5 clk = ~clk;

   sram_arbiter #(.ACCESS_CYCLES(2)) dut_a (
      .clk(clk), .rst(rst),
      .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data_a), .vid_ack(vid_ack_a),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
      .cpu_dout(cpu_dout_a), .cpu_ack(cpu_ack_a),
      .sram_addr(sram_addr_a), .sram_data(bus_a), .sram_we_n(sram_we_n_a)
   );

   sram_arbiter #(.ACCESS_CYCLES(1)) dut_b (
      .clk(clk), .rst(rst),
      .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data_b), .vid_ack(vid_ack_b),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
      .cpu_dout(cpu_dout_b), .cpu_ack(cpu_ack_b),
      .sram_addr(sram_addr_b), .sram_data(bus_b), .sram_we_n(sram_we_n_b)
   );

   // Initial SRAM contents; chosen so address 0x12345 holds 0xA5
   function automatic logic [7:0] pat(input logic [18:0] a);
      return a[7:0] ^ a[15:8] ^ {5'd0, a[18:16]} ^ 8'hC2;
   endfunction

   // Asynchronous SRAM models: drive read data unless the bench expects the DUT to own the bus
   assign sram_q_a = sram_mem_a[sram_addr_a];
   assign sram_q_b = sram_mem_b[sram_addr_b];
   assign bus_a = tb_drv[0] ? sram_q_a : 8'hzz;
   assign bus_b = tb_drv[1] ? sram_q_b : 8'hzz;

   // SRAM A: write on WE_n rising edge
   initial begin : sram_a_proc
      for (int i = 0; i < 524288; i++) sram_mem_a[i] = pat(19'(i));
      forever begin
         @(posedge sram_we_n_a);
         sram_mem_a[sram_addr_a] = bus_a;
      end
   end

   // SRAM B: write on WE_n rising edge
   initial begin : sram_b_proc
      for (int i = 0; i < 524288; i++) sram_mem_b[i] = pat(19'(i));
      forever begin
         @(posedge sram_we_n_b);
         sram_mem_b[sram_addr_b] = bus_b;
      end
   end

   // DUT outputs gathered per instance
   logic        o_vack [2], o_cack [2], o_wen [2];
   logic [7:0]  o_vdata [2], o_cdout [2], o_bus [2], o_sq [2];
   logic [18:0] o_addr [2];
   assign o_vack[0] = vid_ack_a;    assign o_vack[1] = vid_ack_b;
   assign o_cack[0] = cpu_ack_a;    assign o_cack[1] = cpu_ack_b;
   assign o_wen[0]  = sram_we_n_a;  assign o_wen[1]  = sram_we_n_b;
   assign o_vdata[0] = vid_data_a;  assign o_vdata[1] = vid_data_b;
   assign o_cdout[0] = cpu_dout_a;  assign o_cdout[1] = cpu_dout_b;
   assign o_bus[0]  = bus_a;        assign o_bus[1]  = bus_b;
   assign o_sq[0]   = sram_q_a;     assign o_sq[1]   = sram_q_b;
   assign o_addr[0] = sram_addr_a;  assign o_addr[1] = sram_addr_b;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Reference model state per instance
   bit          m_vp [2], m_cp [2], m_cw [2];
   logic [18:0] m_va [2], m_ca [2];
   logic [7:0]  m_cd [2];
   bit          m_busy [2], m_own_cpu [2], m_we [2], m_last_vid [2];
   logic [18:0] m_oa [2], m_eaddr [2];
   logic [7:0]  m_od [2], m_vdata [2], m_cdout [2];
   bit          m_vack [2], m_cack [2];
   int          m_g [2];

   int          last_vack [2], last_cack [2], n_cack [2], vrun [2], max_vrun [2];

   function automatic int acf(input int k);
      return (k == 0) ? 2 : 1;
   endfunction

   task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s inst=%0d cyc=%0d observed=%0h expected=%0h", tag, k, cyc, obs, exp);
      end
   endtask

   // One clock edge of the transaction-level model
   task automatic model_edge(input int k);
      int ac;
      int fin;
      bit pick_cpu;
      ac = acf(k);
      if (rst) begin
         m_vp[k] = 0; m_cp[k] = 0; m_busy[k] = 0; m_last_vid[k] = 0;
         m_vack[k] = 0; m_cack[k] = 0; m_eaddr[k] = '0;
         m_vdata[k] = '0; m_cdout[k] = '0; m_we[k] = 0;
         return;
      end
      m_vack[k] = 0;
      m_cack[k] = 0;
      if (m_busy[k]) begin
         if (vid_req && !m_vp[k] && m_own_cpu[k]) begin
            m_vp[k] = 1; m_va[k] = vid_addr;
         end
         if (cpu_req && !m_cp[k] && !m_own_cpu[k]) begin
            m_cp[k] = 1; m_cw[k] = cpu_we; m_ca[k] = cpu_addr; m_cd[k] = cpu_din;
         end
         fin = m_g[k] + (m_we[k] ? ac + 2 : ac);
         if (cyc == fin) begin
            m_busy[k] = 0;
            if (m_own_cpu[k]) begin
               m_cack[k] = 1;
               if (!m_we[k]) m_cdout[k] = ref_mem[k][m_oa[k]];
            end else begin
               m_vack[k] = 1;
               m_vdata[k] = ref_mem[k][m_oa[k]];
            end
         end
      end else begin
         if (vid_req && !m_vp[k]) begin
            m_vp[k] = 1; m_va[k] = vid_addr;
         end
         if (cpu_req && !m_cp[k]) begin
            m_cp[k] = 1; m_cw[k] = cpu_we; m_ca[k] = cpu_addr; m_cd[k] = cpu_din;
         end
         if (m_vp[k] || m_cp[k]) begin
            pick_cpu = m_cp[k] && (!m_vp[k] || m_last_vid[k]);
            m_busy[k] = 1;
            m_g[k] = cyc;
            m_own_cpu[k] = pick_cpu;
            m_last_vid[k] = !pick_cpu;
            if (pick_cpu) begin
               m_oa[k] = m_ca[k]; m_we[k] = m_cw[k]; m_od[k] = m_cd[k]; m_cp[k] = 0;
               if (m_cw[k]) ref_mem[k][m_ca[k]] = m_cd[k];
            end else begin
               m_oa[k] = m_va[k]; m_we[k] = 0; m_vp[k] = 0;
            end
            m_eaddr[k] = m_oa[k];
         end
      end
   endtask

   // Per-cycle comparison of every observable against the model
   task automatic check_all();
      int d;
      bit drv;
      bit wen;
      for (int k = 0; k < 2; k++) begin
         drv = m_busy[k] && m_we[k];
         d = cyc - m_g[k];
         wen = !(drv && d >= 1 && d <= acf(k));
         chk("vid_ack", k, o_vack[k], m_vack[k]);
         chk("cpu_ack", k, o_cack[k], m_cack[k]);
         chk("vid_data", k, o_vdata[k], m_vdata[k]);
         chk("cpu_dout", k, o_cdout[k], m_cdout[k]);
         chk("sram_addr", k, o_addr[k], m_eaddr[k]);
         chk("sram_we_n", k, o_wen[k], wen);
         if (drv) chk("bus_wdata", k, o_bus[k], m_od[k]);
         else     chk("bus_released", k, o_bus[k], o_sq[k]);
         if (o_vack[k]) begin
            last_vack[k] = cyc;
            vrun[k]++;
            if (vrun[k] > max_vrun[k]) max_vrun[k] = vrun[k];
         end
         if (o_cack[k]) begin
            last_cack[k] = cyc;
            n_cack[k]++;
            vrun[k] = 0;
         end
      end
   endtask

   task automatic step(input bit r, input bit vr, input logic [18:0] va,
                       input bit cr, input bit cw, input logic [18:0] ca, input logic [7:0] cd);
      rst = r; vid_req = vr; vid_addr = va;
      cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_din = cd;
      @(posedge clk);
      cyc++;
      model_edge(0);
      model_edge(1);
      tb_drv[0] = !(m_busy[0] && m_we[0]);
      tb_drv[1] = !(m_busy[1] && m_we[1]);
      #1;
      check_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, '0, 0, 0, '0, '0);
   endtask

   task automatic clr_stats();
      for (int k = 0; k < 2; k++) begin
         last_vack[k] = -1; last_cack[k] = -1; n_cack[k] = 0; vrun[k] = 0; max_vrun[k] = 0;
      end
   endtask

   initial begin : main
      int r0;
      tb_drv[0] = 1; tb_drv[1] = 1;
      for (int i = 0; i < 524288; i++) begin
         ref_mem[0][i] = pat(19'(i));
         ref_mem[1][i] = pat(19'(i));
      end
      clr_stats();

      // Reset state
      step(1, 0, '0, 0, 0, '0, '0);
      step(1, 0, '0, 0, 0, '0, '0);
      idle(2);

      // 1: single video read of 0xA5, latency ACCESS_CYCLES
      clr_stats();
      step(0, 1, 19'h12345, 0, 0, '0, '0);
      r0 = cyc;
      idle(5);
      for (int k = 0; k < 2; k++) begin
         chk("t1_latency", k, last_vack[k] - r0, acf(k));
         chk("t1_vid_data", k, o_vdata[k], 8'hA5);
      end

      // 2: CPU write 0x3C to 0x00010, latency ACCESS_CYCLES+2, then read back
      clr_stats();
      step(0, 0, '0, 1, 1, 19'h00010, 8'h3C);
      r0 = cyc;
      idle(6);
      for (int k = 0; k < 2; k++) chk("t2_wr_latency", k, last_cack[k] - r0, acf(k) + 2);
      step(0, 0, '0, 1, 0, 19'h00010, 8'h00);
      idle(4);
      for (int k = 0; k < 2; k++) chk("t2_readback", k, o_cdout[k], 8'h3C);

      // 3: simultaneous reads; video first, CPU granted in the video ack cycle
      clr_stats();
      step(0, 1, 19'h00020, 1, 0, 19'h00030, 8'h00);
      idle(8);
      for (int k = 0; k < 2; k++) begin
         chk("t3_vid_first", k, (last_vack[k] < last_cack[k]), 1'b1);
         chk("t3_cpu_gap", k, last_cack[k] - last_vack[k], acf(k) + 1);
      end

      // 4: video strobe every 3 cycles with the CPU constantly requesting
      clr_stats();
      for (int i = 0; i < 24; i++) begin
         step(0, (i % 3) == 0, 19'h00500 + 19'(i), 1, 0, 19'h00400 + 19'(i), 8'h00);
      end
      idle(8);
      for (int k = 0; k < 2; k++) chk("t4_alternate", k, (max_vrun[k] <= 1), 1'b1);

      // 5: second CPU strobe while the first is still pending is dropped
      idle(2);
      clr_stats();
      step(0, 1, 19'h00600, 1, 1, 19'h00300, 8'h11);
      step(0, 0, '0, 1, 1, 19'h00301, 8'h22);
      idle(10);
      for (int k = 0; k < 2; k++) chk("t5_one_ack", k, n_cack[k], 1);
      step(0, 0, '0, 1, 0, 19'h00300, 8'h00);
      idle(4);
      for (int k = 0; k < 2; k++) chk("t5_orig_data", k, o_cdout[k], 8'h11);
      step(0, 0, '0, 1, 0, 19'h00301, 8'h00);
      idle(4);
      for (int k = 0; k < 2; k++) chk("t5_untouched", k, o_cdout[k], pat(19'h00301));

      // 6: reset during the WE_n pulse; no ack, pending video request lost
      clr_stats();
      step(0, 0, '0, 1, 1, 19'h7FF00, 8'h5A);
      step(0, 1, 19'h00700, 0, 0, '0, '0);
      step(1, 0, '0, 0, 0, '0, '0);
      for (int k = 0; k < 2; k++) chk("t6_we_n_high", k, o_wen[k], 1'b1);
      idle(8);
      for (int k = 0; k < 2; k++) begin
         chk("t6_no_cpu_ack", k, n_cack[k], 0);
         chk("t6_no_vid_ack", k, last_vack[k], -1);
      end

      // Randomised traffic on a small address window
      for (int i = 0; i < 400; i++) begin
         step(0, $urandom_range(0, 3) == 0, 19'h00100 + 19'($urandom_range(0, 15)),
              $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)),
              19'h00100 + 19'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
      end
      idle(10);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
